lsu_ctrl: RTL and testbench

Load/store controller between the MIPS MEM pipeline stage and the word-wide `ram_bl` data memory. It accepts one byte, half or word request at a time and converts byte addresses to word indices. Loads are returned sign- or zero-extended. Sub-word stores are done as read-modify-write, because the RAM has no byte enables. It also sequences the RAM's registered read port and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/lsu_ctrl_if.sv | 28 ++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store controller.
//   size_t  - request size encoding (byte, half, word, reserved)
//   state_t - controller FSM states
//   *_SHIFT - bit offset of each big-endian lane within a 32-bit word
//   lane_shift() - bit offset of the lane selected by size and byte offset
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        RMW_RD,
        RMW_WR,
        WR,
        RESP
    } state_t;

    // Big-endian: byte offset 0 is the most significant lane.
    localparam logic [4:0] BYTE0_SHIFT = 5'd24;
    localparam logic [4:0] BYTE1_SHIFT = 5'd16;
    localparam logic [4:0] BYTE2_SHIFT = 5'd8;
    localparam logic [4:0] BYTE3_SHIFT = 5'd0;
    localparam logic [4:0] HALF0_SHIFT = 5'd16;
    localparam logic [4:0] HALF2_SHIFT = 5'd0;

    function automatic logic [4:0] lane_shift(input size_t size, input logic [1:0] off);
        logic [4:0] sh;
        sh = 5'd0;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    sh = BYTE0_SHIFT;
                    2'd1:    sh = BYTE1_SHIFT;
                    2'd2:    sh = BYTE2_SHIFT;
                    default: sh = BYTE3_SHIFT;
                endcase
            end
            SZ_HALF: sh = off[1] ? HALF2_SHIFT : HALF0_SHIFT;
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response bundle between the MEM stage and lsu_ctrl.
//   master - the requester (drives req_*, receives req_ready and resp_*)
//   slave  - the controller
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [WORD_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for 32-bit big-endian words.
//   size, off, sgn - latched request size, byte offset and signedness
//   old_word       - word read from the RAM
//   new_data       - right-justified store data
//   load_data      - selected lane, sign- or zero-extended
//   merge_word     - old_word with the addressed lane(s) replaced by new_data
import lsu_pkg::*;

module lsu_lane_align (
    input  size_t       size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    function automatic logic signed [31:0] ext_byte(input logic [7:0] b, input logic s);
        logic signed [31:0] r;
        r = s ? 32'($signed(b)) : $signed({24'd0, b});
        return r;
    endfunction

    function automatic logic signed [31:0] ext_half(input logic [15:0] h, input logic s);
        logic signed [31:0] r;
        r = s ? 32'($signed(h)) : $signed({16'd0, h});
        return r;
    endfunction

    logic [4:0]  shift;
    logic [31:0] lane;
    logic [31:0] lane_mask;

    always_comb begin
        shift     = lane_shift(size, off);
        lane      = old_word >> shift;
        lane_mask = 32'hFFFF_FFFF;
        load_data = old_word;
        case (size)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF;
                load_data = ext_byte(lane[7:0], sgn);
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF;
                load_data = ext_half(lane[15:0], sgn);
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                load_data = old_word;
            end
        endcase
        merge_word = (old_word & ~(lane_mask << shift)) | ((new_data & lane_mask) << shift);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the MEM stage and a word-wide RAM
// with a one-cycle registered read port and no byte enables.
//   clk, rst            - clock, synchronous active-high reset
//   bus (slave)         - one-at-a-time byte/half/word request and response
//   ram_wen, ram_ren    - RAM write/read strobes (never both high)
//   ram_waddr/raddr     - word index of the latched request
//   ram_wdata           - full word to write (merged for sub-word stores)
//   ram_rdata           - registered RAM read data, valid the cycle after ram_ren
import lsu_pkg::*;

module lsu_ctrl #(
    parameter int NUM_WORD   = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_ctrl_if.slave             bus,
    output logic                  ram_wen,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    input  logic [WORD_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_WORD);

    state_t                state;
    state_t                state_nxt;

    logic                  we_q;
    size_t                 size_q;
    logic                  sgn_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [WORD_WIDTH-1:0] rdata_q;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_err;
    logic                  accept;
    logic [WORD_WIDTH-1:0] load_data;
    logic [WORD_WIDTH-1:0] merge_word;

    assign req_idx = {2'b00, bus.req_addr[ADDR_WIDTH-1:2]};

    // Errors are decided at accept time so the FSM can skip memory entirely.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == SZ_RSVD)
            req_err = 1'b1;
        if (bus.req_size == SZ_HALF && bus.req_addr[0])
            req_err = 1'b1;
        if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_idx >= LIMIT)
            req_err = 1'b1;
    end

    assign bus.req_ready = !rst && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    lsu_lane_align u_align (
        .size       (size_q),
        .off        (off_q),
        .sgn        (sgn_q),
        .old_word   (ram_rdata),
        .new_data   (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            off_q   <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= size_t'(bus.req_size);
                sgn_q   <= bus.req_signed;
                off_q   <= bus.req_addr[1:0];
                idx_q   <= req_idx;
                wdata_q <= bus.req_wdata;
                err_q   <= req_err;
            end
            // ram_rdata is only trusted here, one cycle after the RD strobe.
            if (state == CAP)
                rdata_q <= load_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (!bus.req_we)
                        state_nxt = RD;
                    else if (bus.req_size == SZ_WORD)
                        state_nxt = WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = RESP;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and the response are masked by rst so an abort mid-operation
    // produces neither a RAM access nor a completion pulse.
    always_comb begin
        ram_ren   = !rst && (state == RD || state == RMW_RD);
        ram_wen   = !rst && (state == WR || state == RMW_WR);
        ram_wdata = '0;
        if (ram_wen)
            ram_wdata = (state == RMW_WR) ? merge_word : wdata_q;
    end

    assign ram_waddr      = idx_q;
    assign ram_raddr      = idx_q;
    assign bus.resp_valid = !rst && (state == RESP);
    assign bus.resp_err   = bus.resp_valid && err_q;
    assign bus.resp_rdata = rdata_q;

    // Only stores reach WR/RMW_WR; we_q is kept for completeness of the latch.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int NW = 64;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) bus ();

    logic          ram_wen, ram_ren;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0]   ram_wdata, ram_rdata;

    lsu_ctrl #(.NUM_WORD(NW), .ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_wen   (ram_wen),
        .ram_ren   (ram_ren),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Word RAM with registered read; garbage on the read port when not reading.
    logic [31:0] ram_mem [NW];
    always @(posedge clk) begin
        if (ram_wen && ram_waddr < NW) ram_mem[ram_waddr[5:0]] <= ram_wdata;
        if (ram_ren && ram_raddr < NW) ram_rdata <= ram_mem[ram_raddr[5:0]];
        else ram_rdata <= $urandom;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } strobe_t;
    typedef struct { int cyc; logic err; logic [31:0] rdata; } resp_t;
    strobe_t rd_q[$];
    strobe_t wr_q[$];
    resp_t   resp_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [NW];
    logic [31:0] last_rd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT shows a strobe or response.
    always @(negedge clk) begin
        strobe_t s;
        resp_t   r;
        if (rst) begin
            check("ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
            check("strobe_in_rst", {30'd0, ram_ren, ram_wen}, 32'd0);
            check("resp_in_rst", {31'd0, bus.resp_valid}, 32'd0);
        end else begin
            if (ram_ren && ram_wen) flag("both_strobes");
            if (ram_ren) begin
                if (rd_q.size() == 0) flag("unexpected_ren");
                else begin
                    s = rd_q.pop_front();
                    check("ren_cycle", cyc, s.cyc);
                    check("raddr", ram_raddr, s.addr);
                end
            end
            if (ram_wen) begin
                if (wr_q.size() == 0) flag("unexpected_wen");
                else begin
                    s = wr_q.pop_front();
                    check("wen_cycle", cyc, s.cyc);
                    check("waddr", ram_waddr, s.addr);
                    check("wdata", ram_wdata, s.data);
                end
            end
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) flag("unexpected_resp");
                else begin
                    r = resp_q.pop_front();
                    check("resp_cycle", cyc, r.cyc);
                    check("resp_err", {31'd0, bus.resp_err}, {31'd0, r.err});
                    check("resp_rdata", bus.resp_rdata, r.rdata);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) flag("ready_timeout");
    endtask

    // Reference model: big-endian byte array view of each word.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          n, idx, off;
        logic        err;
        logic [7:0]  b [4];
        logic [31:0] w, v;
        logic [15:0] h;
        wait_ready();
        n   = cyc;
        idx = int'(addr >> 2);
        off = int'(addr % 4);
        err = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) ||
              (size == 2'd2 && off != 0) || (addr / 4 >= NW);
        if (err) begin
            resp_q.push_back('{n + 1, 1'b1, last_rd});
        end else begin
            w = mdl[idx];
            for (int k = 0; k < 4; k++) b[k] = w[31 - 8*k -: 8];
            if (!we) begin
                rd_q.push_back('{n + 1, 32'(idx), 32'd0});
                if (size == 2'd0) v = sgn ? 32'($signed(b[off])) : {24'd0, b[off]};
                else if (size == 2'd1) begin
                    h = {b[off], b[off+1]};
                    v = sgn ? 32'($signed(h)) : {16'd0, h};
                end else v = w;
                last_rd = v;
                resp_q.push_back('{n + 3, 1'b0, last_rd});
            end else if (size == 2'd2) begin
                mdl[idx] = wdata;
                wr_q.push_back('{n + 1, 32'(idx), wdata});
                resp_q.push_back('{n + 2, 1'b0, last_rd});
            end else begin
                if (size == 2'd0) b[off] = wdata[7:0];
                else begin
                    b[off]   = wdata[15:8];
                    b[off+1] = wdata[7:0];
                end
                mdl[idx] = {b[0], b[1], b[2], b[3]};
                rd_q.push_back('{n + 1, 32'(idx), 32'd0});
                wr_q.push_back('{n + 2, 32'(idx), mdl[idx]});
                resp_q.push_back('{n + 3, 1'b0, last_rd});
            end
        end
        drive(we, size, sgn, addr, wdata);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          n;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("reset_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("reset_rdata", bus.resp_rdata, 32'd0);
        check("reset_ram_wdata", ram_wdata, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NW; i++) issue(1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom);

        // Word store then load
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
        // Signed/unsigned sub-word loads
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h80FF1234);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'd0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'd0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h22, 32'd0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h20, 32'd0);
        // Byte and half read-modify-write
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h000000AA);
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
        issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000BEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);
        // Error cases
        issue(1'b0, SZ_WORD, 1'b0, 32'h13, 32'd0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h11, 32'd0);
        issue(1'b0, SZ_RSVD, 1'b0, 32'h20, 32'd0);
        issue(1'b1, SZ_RSVD, 1'b0, 32'h20, 32'h12345678);
        issue(1'b0, SZ_WORD, 1'b0, 32'(4 * NW), 32'd0);
        issue(1'b1, SZ_BYTE, 1'b0, 32'(4 * NW + 1), 32'h55);

        // Reset during RMW_RD of a byte store: nothing is written, no response
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
        wait_ready();
        drive(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h000000AA);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
        check("rdata_after_rst", bus.resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 4 * NW + 15));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || resp_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rd_q.size() != 0 || wr_q.size() != 0 || resp_q.size() != 0) flag("drain_timeout");
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
